// File: rtl/rv_irq_ctrl.sv
// rv_irq_ctrl: edge-latching, round-robin interrupt controller that drives a
// single level interrupt into the core's exception unit. Firmware enables
// sources, inspects/clears pending, claims the winning ID and signals
// completion through a four-entry register port.
module rv_irq_ctrl #(
  parameter int G_NUM_SRC = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [G_NUM_SRC-1:0] irq_src_i,
  input  logic [1:0]           reg_sel_i,
  input  logic                 reg_we_i,
  input  logic                 reg_re_i,
  input  logic [31:0]          reg_wdata_i,
  output logic [31:0]          reg_rdata_o,
  output logic                 irq_o
);

  localparam logic [1:0] SEL_ENABLE   = 2'd0;
  localparam logic [1:0] SEL_PENDING  = 2'd1;
  localparam logic [1:0] SEL_CLAIM    = 2'd2;
  localparam logic [1:0] SEL_COMPLETE = 2'd3;

  localparam logic [5:0] NUM_SRC_W = 6'(G_NUM_SRC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_CLAIMED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [G_NUM_SRC-1:0]   enable_q, enable_d;
  logic [G_NUM_SRC-1:0]   pending_q, pending_d;
  logic [G_NUM_SRC-1:0]   src_q;
  logic [4:0]             rr_ptr_q, rr_ptr_d;
  logic [4:0]             cur_id_q, cur_id_d;
  logic                   irq_q, irq_d;

  logic [G_NUM_SRC-1:0]   rise;
  logic [G_NUM_SRC-1:0]   cand;
  logic [G_NUM_SRC-1:0]   cur_mask;
  logic [G_NUM_SRC-1:0]   w1c_mask;
  logic [G_NUM_SRC-1:0]   claim_mask;
  logic [G_NUM_SRC-1:0]   pend_after_w1c;
  logic [G_NUM_SRC-1:0]   rot;
  logic [4:0]             win_off;
  logic [5:0]             win_sum;
  logic [4:0]             win_id;
  logic [5:0]             rr_next;
  logic                   wr_enable, wr_pending, wr_complete, rd_claim;
  logic                   unused_wdata;

  // Register-port strobes decoded once so every consumer sees the same view.
  assign wr_enable   = reg_we_i && (reg_sel_i == SEL_ENABLE);
  assign wr_pending  = reg_we_i && (reg_sel_i == SEL_PENDING);
  assign wr_complete = reg_we_i && (reg_sel_i == SEL_COMPLETE);
  assign rd_claim    = reg_re_i && (reg_sel_i == SEL_CLAIM);

  // Only the low G_NUM_SRC bits (and [4:0] for COMPLETE) carry meaning.
  assign unused_wdata = ^reg_wdata_i;

  assign rise     = irq_src_i & ~src_q;
  assign cand     = pending_q & enable_q;
  assign cur_mask = G_NUM_SRC'(1) << cur_id_q;
  assign w1c_mask = wr_pending ? reg_wdata_i[G_NUM_SRC-1:0] : '0;

  // A claim only clears the bit while the request is actually being presented.
  assign claim_mask = ((state_q == S_ASSERT) && rd_claim) ? cur_mask : '0;

  // Set beats clear when an edge and a clear land on the same bit.
  assign pend_after_w1c = (pending_q & ~w1c_mask) | rise;
  assign pending_d      = (pending_q & ~(w1c_mask | claim_mask)) | rise;
  assign enable_d       = wr_enable ? reg_wdata_i[G_NUM_SRC-1:0] : enable_q;

  // Round-robin pick: rotate candidates so rr_ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to an absolute source ID.
  always_comb begin
    rot     = G_NUM_SRC'({cand, cand} >> rr_ptr_q);
    win_off = '0;
    for (int k = G_NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) win_off = 5'(k);
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= NUM_SRC_W) win_sum = win_sum - NUM_SRC_W;
    win_id = win_sum[4:0];
  end

  // Pointer value that makes the just-completed source lowest priority next.
  always_comb begin
    rr_next = {1'b0, cur_id_q} + 6'd1;
    if (rr_next >= NUM_SRC_W) rr_next = '0;
  end

  // Next-state logic: present one winner, hold it until claim or until its
  // pending/enable bit vanishes, then wait for the matching completion.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (|cand) begin
          state_d  = S_ASSERT;
          cur_id_d = win_id;
        end
      end
      S_ASSERT: begin
        if (rd_claim) begin
          state_d = S_CLAIMED;
        end else if (!(|(pend_after_w1c & enable_d & cur_mask))) begin
          state_d = S_IDLE;
        end
      end
      S_CLAIMED: begin
        if (wr_complete && (reg_wdata_i[4:0] == cur_id_q)) begin
          state_d  = S_IDLE;
          rr_ptr_d = rr_next[4:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    irq_d = (state_d == S_ASSERT);
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      src_q     <= '0;
      rr_ptr_q  <= '0;
      cur_id_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      src_q     <= irq_src_i;
      rr_ptr_q  <= rr_ptr_d;
      cur_id_q  <= cur_id_d;
      irq_q     <= irq_d;
    end
  end

  // Read mux reflects current state; CLAIM shows the ID only while asserting.
  always_comb begin
    reg_rdata_o = '0;
    unique case (reg_sel_i)
      SEL_ENABLE:   reg_rdata_o[G_NUM_SRC-1:0] = enable_q;
      SEL_PENDING:  reg_rdata_o[G_NUM_SRC-1:0] = pending_q;
      SEL_CLAIM: begin
        if (state_q == S_ASSERT) reg_rdata_o = {1'b1, 26'b0, cur_id_q};
      end
      SEL_COMPLETE: reg_rdata_o[0] = (state_q == S_CLAIMED);
      default:      reg_rdata_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_rv_irq_ctrl.sv
// Directed bench for rv_irq_ctrl: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_rv_irq_ctrl;

  localparam int N = 8;
  localparam logic [1:0] R_EN = 2'd0, R_PEND = 2'd1, R_CLAIM = 2'd2, R_COMP = 2'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_src;
  logic [1:0]   reg_sel;
  logic         reg_we, reg_re;
  logic [31:0]  reg_wdata;
  logic [31:0]  reg_rdata;
  logic         irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  rv_irq_ctrl #(.G_NUM_SRC(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_src_i  (irq_src),
    .reg_sel_i  (reg_sel),
    .reg_we_i   (reg_we),
    .reg_re_i   (reg_re),
    .reg_wdata_i(reg_wdata),
    .reg_rdata_o(reg_rdata),
    .irq_o      (irq)
  );

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_q.push_back('{tag: tag, exp: exp});
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    reg_sel   = sel;
    reg_wdata = data;
    reg_we    = 1'b1;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    reg_sel = sel;
    sb_push(tag, exp);
    #1;
    sb_check(reg_rdata);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    sb_push(tag, {31'b0, exp});
    sb_check({31'b0, irq});
  endtask

  // Side-effecting CLAIM read: data checked while the strobe is high.
  task automatic claim(input logic [31:0] exp, input string tag);
    reg_sel = R_CLAIM;
    reg_re  = 1'b1;
    sb_push(tag, exp);
    #1;
    sb_check(reg_rdata);
    tick();
    reg_re = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    irq_src = mask;
    tick();
    irq_src = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; irq_src = '0; reg_sel = '0; reg_we = 1'b0; reg_re = 1'b0; reg_wdata = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    chk_irq(1'b0, "rst_irq");
    rd(R_EN,    32'h0, "rst_enable");
    rd(R_PEND,  32'h0, "rst_pending");
    rd(R_CLAIM, 32'h0, "rst_claim");
    rd(R_COMP,  32'h0, "rst_complete");

    // Enable bits beyond the source count read as zero
    wr(R_EN, 32'hFFFF_FFFF);
    rd(R_EN, 32'h0000_00FF, "enable_width");

    // Single source 3: latency, claim, complete
    pulse(8'h08);
    rd(R_PEND, 32'h08, "t1_pending_1edge");
    chk_irq(1'b0, "t1_irq_1edge");
    tick();
    chk_irq(1'b1, "t1_irq_2edge");
    claim(32'h8000_0003, "t1_claim3");
    chk_irq(1'b0, "t1_irq_after_claim");
    rd(R_PEND, 32'h00, "t1_pending_cleared");
    rd(R_COMP, 32'h01, "t1_complete_claimed");
    wr(R_COMP, 32'd3);
    rd(R_COMP, 32'h00, "t1_complete_idle");

    // Round-robin from rr_ptr=0
    do_reset();
    wr(R_EN, 32'hFF);
    pulse(8'h22);
    tick();
    chk_irq(1'b1, "t2_irq_a");
    claim(32'h8000_0001, "t2_claim1");
    wr(R_COMP, 32'd1);
    chk_irq(1'b0, "t2_irq_gap");
    tick();
    chk_irq(1'b1, "t2_reassert_1cycle");
    claim(32'h8000_0005, "t2_claim5");
    wr(R_COMP, 32'd5);
    // rr_ptr is now 6: scan 6,7,0,1 finds 1 before 5
    pulse(8'h22);
    tick();
    claim(32'h8000_0001, "t2_wrap_claim1");
    wr(R_PEND, 32'h20);
    wr(R_COMP, 32'd1);
    rd(R_PEND, 32'h00, "t2_pending_clean");

    // Disabled source stays pending without requesting
    wr(R_EN, 32'h00);
    pulse(8'h04);
    rd(R_PEND, 32'h04, "t3_pending_disabled");
    tick(); tick();
    chk_irq(1'b0, "t3_irq_disabled");
    wr(R_EN, 32'h04);
    chk_irq(1'b0, "t3_irq_1edge");
    tick();
    chk_irq(1'b1, "t3_irq_2edge");
    claim(32'h8000_0002, "t3_claim2");
    wr(R_COMP, 32'd2);
    wr(R_EN, 32'hFF);

    // W1C of the asserted source withdraws the request
    pulse(8'h40);
    tick();
    rd(R_CLAIM, 32'h8000_0006, "t4_claim_peek6");
    wr(R_PEND, 32'h40);
    chk_irq(1'b0, "t4_irq_withdrawn");
    rd(R_CLAIM, 32'h0, "t4_claim_idle");
    rd(R_PEND, 32'h0, "t4_pending_w1c");

    // Set beats W1C on the same cycle
    pulse(8'h40);
    tick();
    irq_src   = 8'h40;
    reg_sel   = R_PEND;
    reg_wdata = 32'h40;
    reg_we    = 1'b1;
    tick();
    reg_we = 1'b0; reg_wdata = '0; irq_src = '0;
    rd(R_PEND, 32'h40, "t4_set_wins");
    chk_irq(1'b1, "t4_irq_kept");
    claim(32'h8000_0006, "t4_claim6");
    wr(R_COMP, 32'd6);

    // Mismatching COMPLETE ignored; re-pend during CLAIMED re-served
    pulse(8'h10);
    tick();
    claim(32'h8000_0004, "t5_claim4");
    wr(R_COMP, 32'd2);
    rd(R_COMP, 32'h01, "t5_complete_ignored");
    chk_irq(1'b0, "t5_irq_claimed");
    pulse(8'h10);
    rd(R_PEND, 32'h10, "t5_repend");
    wr(R_COMP, 32'd4);
    tick();
    chk_irq(1'b1, "t5_reassert");
    rd(R_CLAIM, 32'h8000_0004, "t5_claim_peek4");

    // Reset mid-ASSERT
    do_reset();
    chk_irq(1'b0, "t6_irq");
    rd(R_PEND,  32'h0, "t6_pending");
    rd(R_EN,    32'h0, "t6_enable");
    rd(R_CLAIM, 32'h0, "t6_claim");

    // A held-high line yields exactly one pending event
    irq_src = 8'h01;
    tick();
    rd(R_PEND, 32'h01, "t7_level_first");
    wr(R_PEND, 32'h01);
    tick(); tick();
    rd(R_PEND, 32'h00, "t7_level_no_repeat");
    irq_src = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
